// File: rtl/serial_eq_pkg.sv
// Shared types and helpers for the bit-serial word comparator (serial_eq_ctrl).
package serial_eq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a bit index into a width-bit word, never less than one bit.
    function automatic int idx_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/eq1.sv
// 1-bit equality cell shared by the serial comparator: out=1 when b1 equals b2.
module eq1 (
    input  logic b1,
    input  logic b2,
    output logic out
);

    assign out = ~(b1 ^ b2);

endmodule

// File: rtl/serial_eq_ctrl.sv
// Bit-serial WIDTH-bit equality sequencer, LSB first, with start/busy/done handshake.
// Optional build macro SERIAL_EQ_EARLY_EXIT_EN ends the scan at the first mismatch.
module serial_eq_ctrl
    import serial_eq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [IDX_W-1:0] mismatch_idx
);

    localparam int               CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   cnt;
    logic               eq_acc;
    logic [IDX_W-1:0]   idx_r;
    logic               bit_eq;
    logic               accept;

    eq1 u_eq1 (
        .b1  (a_sh[0]),
        .b2  (b_sh[0]),
        .out (bit_eq)
    );

    assign accept = (state == S_IDLE) && start;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (start) state_next = S_SCAN;
            S_SCAN: begin
                if (cnt == LAST) state_next = S_DONE;
`ifdef SERIAL_EQ_EARLY_EXIT_EN
                else if (!bit_eq) state_next = S_DONE;
`endif
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // NOTE: datapath registers are reset too, because equal/mismatch_idx are observable right after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            eq_acc <= 1'b0;
            idx_r  <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            cnt    <= '0;
            eq_acc <= 1'b1;
            idx_r  <= '0;
        end else if (state == S_SCAN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CNT_W'(1);
            // Only the first mismatch is recorded; eq_acc guards later ones.
            if (!bit_eq && eq_acc) begin
                eq_acc <= 1'b0;
                idx_r  <= cnt[IDX_W-1:0];
            end
        end
    end

    assign equal        = eq_acc;
    assign mismatch_idx = idx_r;

endmodule

// File: tb/tb_serial_eq_ctrl.sv
// Self-checking bench for serial_eq_ctrl (WIDTH=8); honours SERIAL_EQ_EARLY_EXIT_EN.
module tb_serial_eq_ctrl;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             equal;
    logic [IDX_W-1:0] mismatch_idx;

    int vectors     = 0;
    int miscompares = 0;

    serial_eq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .equal        (equal),
        .mismatch_idx (mismatch_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: equality, lowest differing bit, and cycles from accept to done.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                         output logic r_eq, output int r_idx, output int r_lat);
        logic [WIDTH-1:0] diff;
        diff  = ma ^ mb;
        r_eq  = (diff == '0);
        r_idx = 0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (diff[i]) r_idx = i;
`ifdef SERIAL_EQ_EARLY_EXIT_EN
        r_lat = r_eq ? WIDTH : r_idx + 1;
`else
        r_lat = WIDTH;
`endif
    endtask

    task automatic run_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input bit disturb);
        logic r_eq;
        int   r_idx;
        int   r_lat;
        int   lat;
        int   extra;
        model(ta, tb_v, r_eq, r_idx, r_lat);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
        lat = 0;
        check("busy_scan", 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            if (disturb && lat == 1) begin
                start = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(lat), 32'(r_lat));
        check("equal", 32'(equal), 32'(r_eq));
        check("mismatch_idx", 32'(mismatch_idx), 32'(r_idx));
        @(negedge clk);
        check("done_pulse_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("equal_held", 32'(equal), 32'(r_eq));
        check("idx_held", 32'(mismatch_idx), 32'(r_idx));
        if (disturb) begin
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("no_extra_done", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int last;
        int n;
        int spins;
        int extra;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_equal", 32'(equal), 32'd0);
        check("rst_idx", 32'(mismatch_idx), 32'd0);
        rst_n = 1'b1;

        // Directed cases, including a late mismatch and a second mismatch that must not move the index.
        run_cmp(8'hA5, 8'hA5, 1'b0);
        run_cmp(8'hA5, 8'h25, 1'b0);
        run_cmp(8'h0F, 8'h0B, 1'b0);
        run_cmp(8'h0F, 8'h8B, 1'b0);
        run_cmp(8'h00, 8'h01, 1'b0);
        run_cmp(8'hC3, 8'h43, 1'b1);

        // Abort with reset in the 4th SCAN cycle.
        @(negedge clk);
        a = 8'h3C; b = 8'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_equal", 32'(equal), 32'd0);
        check("abort_idx", 32'(mismatch_idx), 32'd0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);
        run_cmp(8'h5A, 8'h1A, 1'b0);

        // Random operands, half of them with a single forced bit difference.
        for (int k = 0; k < 20; k++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            if (k % 2 == 0) rb = ra ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
            else            rb = WIDTH'($urandom);
            if (k % 5 == 0) rb = ra;
            run_cmp(ra, rb, (k % 4 == 3));
        end

        // start held high: back-to-back compares every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        last = -1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_equal", 32'(equal), 32'd1);
                if (last >= 0) check("b2b_spacing", 32'(c - last), 32'(WIDTH + 2));
                last = c;
                n++;
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(n), 32'd3);
        spins = 0;
        while (busy && spins < 40) begin
            @(negedge clk);
            spins++;
        end
        check("b2b_drain_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
